spectrum_frame_seq: RTL and testbench

Parametrised frame sequencer between the forward FFT and the pitch-shift back end. It pulls one full FFT frame into a ping-pong bin buffer and tracks the peak-magnitude bin during capture. It then swaps banks so the IFFT side reads a stable frame while the next frame is captured. It generalises the single-buffer capture stage with configurable width and depth, double buffering and variable-latency FFT reads.

---
 rtl/spectrum_frame_seq_pkg.sv | 48 ++++
 rtl/spectrum_pingpong_ram.sv | 40 ++++
 rtl/spectrum_frame_seq.sv | 190 +++++++++++++++++++
 tb/tb_spectrum_frame_seq.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spectrum_frame_seq_pkg.sv
// Shared types and helpers for the spectrum frame sequencer: FSM encoding,
// {re,im} bin-word slicing and the |re|+|im| magnitude estimate.
package spectrum_frame_seq_pkg;

  // Upper bound on DATA_W supported by the slicing and magnitude helpers
  localparam int unsigned SEQ_MAX_DATA_W = 32;
  localparam int unsigned WORD_MAX_W     = 2 * SEQ_MAX_DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_SWAP  = 3'd4
  } seq_state_e;

  // Real part lives in the upper data_w bits of the (zero-extended) bin word
  function automatic logic signed [SEQ_MAX_DATA_W-1:0] bin_re(
    input logic [WORD_MAX_W-1:0] word,
    input int unsigned           data_w
  );
    logic signed [WORD_MAX_W-1:0] w;
    w = $signed(word << (WORD_MAX_W - 2 * data_w));
    return SEQ_MAX_DATA_W'(w >>> (WORD_MAX_W - data_w));
  endfunction

  function automatic logic signed [SEQ_MAX_DATA_W-1:0] bin_im(
    input logic [WORD_MAX_W-1:0] word,
    input int unsigned           data_w
  );
    logic signed [WORD_MAX_W-1:0] w;
    w = $signed(word << (WORD_MAX_W - data_w));
    return SEQ_MAX_DATA_W'(w >>> (WORD_MAX_W - data_w));
  endfunction

  // Unsigned abs keeps the most negative input exact (no saturation)
  function automatic logic [SEQ_MAX_DATA_W:0] bin_mag(
    input logic signed [SEQ_MAX_DATA_W-1:0] re,
    input logic signed [SEQ_MAX_DATA_W-1:0] im
  );
    logic [SEQ_MAX_DATA_W-1:0] a_re;
    logic [SEQ_MAX_DATA_W-1:0] a_im;
    a_re = re[SEQ_MAX_DATA_W-1] ? SEQ_MAX_DATA_W'(-re) : SEQ_MAX_DATA_W'(re);
    a_im = im[SEQ_MAX_DATA_W-1] ? SEQ_MAX_DATA_W'(-im) : SEQ_MAX_DATA_W'(im);
    return {1'b0, a_re} + {1'b0, a_im};
  endfunction

endpackage

// File: rtl/spectrum_pingpong_ram.sv
// Two-bank bin buffer: writes go to the bank not selected for reading,
// reads have one cycle of registered latency (block-RAM friendly).
module spectrum_pingpong_ram #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned WORD_W = 36
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bank_sel_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WORD_W-1:0] rd_data_o
);

  localparam int unsigned DEPTH = 2 ** (ADDR_W + 1);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[{~bank_sel_i, wr_addr_i}] <= wr_data_i;
    end
  end

  // Output register only is reset; array contents persist across reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[{bank_sel_i, rd_addr_i}];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/spectrum_frame_seq.sv
// Frame sequencer between forward FFT and pitch-shift back end: captures a frame
// into a ping-pong buffer, tracks the peak bin, swaps banks. PEAK_SKIP_DC_EN excludes bin 0 from the peak.
module spectrum_frame_seq
  import spectrum_frame_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 18,
  parameter int unsigned MAG_W  = DATA_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  done,
  input  logic                  fft_done,
  output logic [ADDR_W-1:0]     fft_address,
  output logic                  fft_read_enable,
  input  logic                  fft_read_valid,
  input  logic [2*DATA_W-1:0]   fft_data,
  input  logic [ADDR_W-1:0]     result_address,
  input  logic                  result_read_enable,
  output logic [2*DATA_W-1:0]   result_data,
  output logic                  result_read_valid,
  output logic [ADDR_W-1:0]     peak_index,
  output logic [MAG_W-1:0]      peak_mag,
  output logic                  peak_valid
);

  localparam int unsigned N      = 2 ** ADDR_W;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned WORD_W = 2 * DATA_W;

`ifdef PEAK_SKIP_DC_EN
  localparam logic SKIP_DC = 1'b1;
`else
  localparam logic SKIP_DC = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] IDX_INIT = SKIP_DC ? ADDR_W'(1) : '0;

  seq_state_e        state_q, state_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              bank_q, bank_d;
  logic [MAG_W-1:0]  run_max_q, run_max_d;
  logic [ADDR_W-1:0] run_idx_q, run_idx_d;
  logic [ADDR_W-1:0] peak_index_q, peak_index_d;
  logic [MAG_W-1:0]  peak_mag_q, peak_mag_d;
  logic              peak_valid_q, peak_valid_d;
  logic              res_valid_q;

  logic                             beat_c;
  logic                             track_c;
  logic signed [SEQ_MAX_DATA_W-1:0] re_c;
  logic signed [SEQ_MAX_DATA_W-1:0] im_c;
  logic [MAG_W-1:0]                 mag_c;

  // Returns are accepted only while a frame is in flight and not yet complete
  assign beat_c  = fft_read_valid && (state_q == ST_FETCH || state_q == ST_DRAIN)
                   && (cnt_q != CNT_W'(N));
  assign track_c = beat_c && !(SKIP_DC && cnt_q == '0);
  assign re_c    = bin_re(WORD_MAX_W'(fft_data), DATA_W);
  assign im_c    = bin_im(WORD_MAX_W'(fft_data), DATA_W);
  assign mag_c   = MAG_W'(bin_mag(re_c, im_c));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      done_q       <= 1'b1;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      bank_q       <= 1'b0;
      run_max_q    <= '0;
      run_idx_q    <= '0;
      peak_index_q <= '0;
      peak_mag_q   <= '0;
      peak_valid_q <= 1'b0;
      res_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_q       <= done_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      bank_q       <= bank_d;
      run_max_q    <= run_max_d;
      run_idx_q    <= run_idx_d;
      peak_index_q <= peak_index_d;
      peak_mag_q   <= peak_mag_d;
      peak_valid_q <= peak_valid_d;
      res_valid_q  <= result_read_enable;
    end
  end

  always_comb begin
    state_d      = state_q;
    done_d       = done_q;
    rd_en_d      = rd_en_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    bank_d       = bank_q;
    run_max_d    = run_max_q;
    run_idx_d    = run_idx_q;
    peak_index_d = peak_index_q;
    peak_mag_d   = peak_mag_q;
    peak_valid_d = peak_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ARM;
          done_d  = 1'b0;
          pend_d  = fft_done;
        end
      end
      ST_ARM: begin
        if (fft_done || pend_q) begin
          state_d   = ST_FETCH;
          rd_en_d   = 1'b1;
          addr_d    = '0;
          cnt_d     = '0;
          pend_d    = 1'b0;
          run_max_d = '0;
          run_idx_d = IDX_INIT;
        end
      end
      ST_FETCH: begin
        if (addr_q == ADDR_W'(N - 1)) begin
          state_d = ST_DRAIN;
          rd_en_d = 1'b0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        // Leave on the final beat itself so done rises one cycle after it
        if (cnt_q == CNT_W'(N) || (beat_c && cnt_q == CNT_W'(N - 1))) begin
          state_d = ST_SWAP;
        end
      end
      ST_SWAP: begin
        state_d      = ST_IDLE;
        done_d       = 1'b1;
        bank_d       = ~bank_q;
        peak_index_d = run_idx_q;
        peak_mag_d   = run_max_q;
        peak_valid_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Strict greater-than keeps the lowest index on ties
    if (beat_c) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (track_c && mag_c > run_max_q) begin
        run_max_d = mag_c;
        run_idx_d = cnt_q[ADDR_W-1:0];
      end
    end
  end

  spectrum_pingpong_ram #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_ram (
    .clk        (clk),
    .rst_n      (rst_n),
    .bank_sel_i (bank_q),
    .wr_en_i    (beat_c),
    .wr_addr_i  (cnt_q[ADDR_W-1:0]),
    .wr_data_i  (fft_data),
    .rd_en_i    (result_read_enable),
    .rd_addr_i  (result_address),
    .rd_data_o  (result_data)
  );

  assign done              = done_q;
  assign fft_read_enable   = rd_en_q;
  assign fft_address       = addr_q;
  assign result_read_valid = res_valid_q;
  assign peak_index        = peak_index_q;
  assign peak_mag          = peak_mag_q;
  assign peak_valid        = peak_valid_q;

endmodule

// File: tb/tb_spectrum_frame_seq.sv
// Self-checking bench for spectrum_frame_seq: FFT source model with fixed or
// jittered return latency, an IFFT-side reader, and a frame-level peak model.
module tb_spectrum_frame_seq;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 18;
  localparam int unsigned MAG_W  = 19;
  localparam int unsigned N      = 512;
  localparam int unsigned WORD_W = 36;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              done;
  logic              fft_done;
  logic [ADDR_W-1:0] fft_address;
  logic              fft_read_enable;
  logic              fft_read_valid = 1'b0;
  logic [WORD_W-1:0] fft_data = '0;
  logic [ADDR_W-1:0] result_address = '0;
  logic              result_read_enable = 1'b0;
  logic [WORD_W-1:0] result_data;
  logic              result_read_valid;
  logic [ADDR_W-1:0] peak_index;
  logic [MAG_W-1:0]  peak_mag;
  logic              peak_valid;

  spectrum_frame_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAG_W(MAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .fft_done(fft_done),
    .fft_address(fft_address), .fft_read_enable(fft_read_enable),
    .fft_read_valid(fft_read_valid), .fft_data(fft_data),
    .result_address(result_address), .result_read_enable(result_read_enable),
    .result_data(result_data), .result_read_valid(result_read_valid),
    .peak_index(peak_index), .peak_mag(peak_mag), .peak_valid(peak_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct { int addr; int rel; } req_t;
  req_t reqq[$];

  logic [WORD_W-1:0] fdata [N];
  logic [WORD_W-1:0] rview [N];
  int   cyc = 0, en_cnt = 0, en_runs = 0, addr_err = 0, exp_req = 0;
  int   last_beat_cyc = 0, gap = 0, frames_done = 0, base_frames = 0, mode = 0;
  bit   jitter = 0, in_abort = 0, rview_valid = 0, en_prev = 0, rd_pend = 0;
  logic done_prev = 1'b1;
  logic [WORD_W-1:0] rd_exp = '0;

  function automatic logic [WORD_W-1:0] mk(input int re, input int im);
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] i;
    r = DATA_W'(re);
    i = DATA_W'(im);
    return {r, i};
  endfunction

  function automatic int mref(input logic [WORD_W-1:0] w);
    logic signed [DATA_W-1:0] r;
    logic signed [DATA_W-1:0] i;
    int ri, ii;
    r  = w[WORD_W-1:DATA_W];
    i  = w[DATA_W-1:0];
    ri = int'(r);
    ii = int'(i);
    if (ri < 0) ri = -ri;
    if (ii < 0) ii = -ii;
    return ri + ii;
  endfunction

  // Frame-level peak rule: largest magnitude, lowest index on ties
  task automatic ref_peak(output int idx, output int mag);
    int first;
`ifdef PEAK_SKIP_DC_EN
    first = 1;
`else
    first = 0;
`endif
    idx = first;
    mag = 0;
    for (int k = first; k < int'(N); k++) begin
      if (mref(fdata[k]) > mag) begin
        mag = mref(fdata[k]);
        idx = k;
      end
    end
  endtask

  task automatic fill_small(input int lim);
    for (int k = 0; k < int'(N); k++) begin
      fdata[k] = mk(int'($urandom_range(2 * lim)) - lim, int'($urandom_range(2 * lim)) - lim);
    end
  endtask

  // FFT source, request monitor, frame-boundary tracker and IFFT reader
  always @(negedge clk) begin
    req_t e;
    cyc++;
    if (fft_read_enable === 1'b1) begin
      if (fft_address !== ADDR_W'(exp_req)) addr_err++;
      exp_req++;
      en_cnt++;
      if (!en_prev) en_runs++;
      e.addr = int'(fft_address);
      e.rel  = cyc + (jitter ? 1 : 3);
      reqq.push_back(e);
    end
    en_prev = (fft_read_enable === 1'b1);

    fft_read_valid = 1'b0;
    if (gap > 0) begin
      gap--;
    end else if (reqq.size() > 0 && reqq[0].rel <= cyc) begin
      e = reqq.pop_front();
      fft_read_valid = 1'b1;
      fft_data = fdata[e.addr];
      if (e.addr == int'(N) - 1) last_beat_cyc = cyc;
      if (jitter) gap = int'($urandom_range(5));
    end

    if (done === 1'b1 && done_prev === 1'b0 && !in_abort) begin
      chk("done_latency", 64'(cyc - last_beat_cyc), 64'(2));
      rview = fdata;
      rview_valid = 1;
      frames_done++;
    end
    done_prev = done;

    if (rd_pend) begin
      chk("res_valid", 64'(result_read_valid), 64'(1));
      chk("res_data", 64'(result_data), 64'(rd_exp));
    end else begin
      chk("res_idle_valid", 64'(result_read_valid), 64'(0));
    end
    if (mode != 0 && rview_valid) begin
      result_address     = (mode == 1) ? ADDR_W'(5) : ADDR_W'($urandom_range(N - 1));
      result_read_enable = 1'b1;
      rd_exp             = rview[result_address];
      rd_pend            = 1;
    end else begin
      result_read_enable = 1'b0;
      rd_pend            = 0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // dly = cycles from the accepted start to fft_done (0 = same cycle)
  task automatic start_frame(input int dly, input bit jit);
    jitter = jit; en_cnt = 0; en_runs = 0; addr_err = 0; exp_req = 0;
    base_frames = frames_done;
    start = 1'b1;
    fft_done = (dly == 0);
    tick();
    start = 1'b0;
    fft_done = 1'b0;
    chk("done_fall", 64'(done), 64'(0));
    if (dly > 0) begin
      tick(dly - 1);
      chk("arm_waits", 64'(en_cnt), 64'(0));
      fft_done = 1'b1;
      tick();
      fft_done = 1'b0;
    end
  endtask

  task automatic wait_frame(input string tag);
    int budget, idx, mag;
    budget = 20000;
    while (frames_done == base_frames && budget > 0) begin
      tick();
      budget--;
    end
    chk({tag, "/frame_complete"}, 64'(frames_done), 64'(base_frames + 1));
    ref_peak(idx, mag);
    chk({tag, "/peak_index"}, 64'(peak_index), 64'(idx));
    chk({tag, "/peak_mag"}, 64'(peak_mag), 64'(mag));
    chk({tag, "/peak_valid"}, 64'(peak_valid), 64'(1));
    chk({tag, "/done"}, 64'(done), 64'(1));
    chk({tag, "/req_count"}, 64'(en_cnt), 64'(N));
    chk({tag, "/req_contiguous"}, 64'(en_runs), 64'(1));
    chk({tag, "/req_addr_errs"}, 64'(addr_err), 64'(0));
  endtask

  initial begin
    int budget;
    rst_n = 1'b0; start = 1'b0; fft_done = 1'b0;
    tick(3);
    chk("rst/done", 64'(done), 64'(1));
    chk("rst/rd_en", 64'(fft_read_enable), 64'(0));
    chk("rst/addr", 64'(fft_address), 64'(0));
    chk("rst/res_valid", 64'(result_read_valid), 64'(0));
    chk("rst/res_data", 64'(result_data), 64'(0));
    chk("rst/peak_index", 64'(peak_index), 64'(0));
    chk("rst/peak_mag", 64'(peak_mag), 64'(0));
    chk("rst/peak_valid", 64'(peak_valid), 64'(0));
    rst_n = 1'b1;
    tick(2);

    // Ramp frame, fixed latency, fft_done one cycle after start
    for (int k = 0; k < int'(N); k++) fdata[k] = mk(k, 0);
    start_frame(1, 0);
    wait_frame("ramp");
    chk("ramp/peak511", 64'(peak_index), 64'(511));
    chk("ramp/mag511", 64'(peak_mag), 64'(511));
    mode = 2;
    tick(40);

    // Jittered returns, most negative value at bin 37; start during FETCH ignored
    fill_small(100);
    fdata[37] = mk(-(1 << 17), -(1 << 17));
    start_frame(0, 1);
    budget = 5000;
    while (en_cnt < 50 && budget > 0) begin tick(); budget--; end
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_frame("jitter");
    chk("jitter/peak37", 64'(peak_index), 64'(37));
    chk("jitter/mag2p18", 64'(peak_mag), 64'(1 << 18));
    tick(6);
    chk("start_ignored/done", 64'(done), 64'(1));
    chk("start_ignored/reqs", 64'(en_cnt), 64'(N));

    // Tie at bins 10 and 200; fft_done while idle must not arm
    fill_small(60);
    fdata[10]  = mk(300, -200);
    fdata[200] = mk(-250, 250);
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    tick(3);
    chk("idle_fft_done/rd_en", 64'(fft_read_enable), 64'(0));
    start_frame(8, 0);
    wait_frame("tie");
    chk("tie/index10", 64'(peak_index), 64'(10));

    // Back-to-back frames while the IFFT side reads bin 5 every cycle
    mode = 1;
    fill_small(100);
    fdata[5] = mk(11, -11);
    start_frame(0, 1);
    wait_frame("b2b1");
    fill_small(100);
    fdata[5] = mk(-7, 7);
    start_frame(0, 0);
    wait_frame("b2b2");
    tick(5);
    mode = 2;
    tick(20);

    // DC bin largest, bin 3 next
    fill_small(90);
    fdata[0] = mk(1000, 0);
    fdata[3] = mk(500, 0);
    start_frame(0, 0);
    wait_frame("dc");
`ifdef PEAK_SKIP_DC_EN
    chk("dc/index", 64'(peak_index), 64'(3));
`else
    chk("dc/index", 64'(peak_index), 64'(0));
`endif

    // Reset mid-FETCH at bin 100, then stray returns
    mode = 0;
    tick(3);
    in_abort = 1;
    fill_small(50);
    start_frame(0, 0);
    budget = 2000;
    while (!(fft_read_enable === 1'b1 && fft_address == ADDR_W'(100)) && budget > 0) begin
      tick();
      budget--;
    end
    chk("abort/reached_bin100", 64'(fft_address), 64'(100));
    rst_n = 1'b0;
    tick();
    chk("abort/done", 64'(done), 64'(1));
    chk("abort/peak_valid", 64'(peak_valid), 64'(0));
    chk("abort/rd_en", 64'(fft_read_enable), 64'(0));
    chk("abort/peak_index", 64'(peak_index), 64'(0));
    chk("abort/peak_mag", 64'(peak_mag), 64'(0));
    rst_n = 1'b1;
    budget = 100;
    while (reqq.size() > 0 && budget > 0) begin tick(); budget--; end
    tick(5);
    chk("stray/done", 64'(done), 64'(1));
    chk("stray/rd_en", 64'(fft_read_enable), 64'(0));
    chk("stray/peak_valid", 64'(peak_valid), 64'(0));
    rview_valid = 0;
    in_abort = 0;

    // Recovery frame after the abort
    fill_small(200);
    start_frame(1, 1);
    wait_frame("recover");
    mode = 2;
    tick(30);
    mode = 0;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
